result_dispatcher: RTL

RESULT_DISPATCHER -- requirements
Module: result_dispatcher

---
 rtl/ip_pkg.sv | 21 ++
 rtl/skid_buf2.sv | 61 ++++++
 rtl/result_dispatcher.sv | 106 ++++++++++
 3 files changed

// File: rtl/ip_pkg.sv
//------------------------------------------------------------------------------
// Module  : ip_pkg
// Brief   : Shared width default and dispatcher state encoding.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package ip_pkg;

    localparam int unsigned c_DW_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_CMPLT  = 2'd3
    } disp_state_t;

endpackage

`default_nettype wire

// File: rtl/skid_buf2.sv
//------------------------------------------------------------------------------
// Module  : skid_buf2
// Brief   : Two-entry in-order buffer; r_d0 is always the head word.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module skid_buf2
    import ip_pkg::*;
#(
    parameter int DW = c_DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [DW-1:0] i_push_data,
    input  logic          i_pop,
    output logic [1:0]    o_occ,
    output logic [DW-1:0] o_head
);

    logic [DW-1:0] r_d0;
    logic [DW-1:0] r_d1;
    logic [1:0]    r_occ;

    // Push into a full buffer and pop from an empty one are excluded by the caller.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ <= 2'd0;
            r_d0  <= '0;
            r_d1  <= '0;
        end else begin
            case ({i_push, i_pop})
                2'b10: begin
                    if (r_occ == 2'd0) r_d0 <= i_push_data;
                    else               r_d1 <= i_push_data;
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_d0  <= r_d1;
                    r_occ <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd1) begin
                        r_d0 <= i_push_data;
                    end else begin
                        r_d0 <= r_d1;
                        r_d1 <= i_push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_occ  = r_occ;
    assign o_head = r_d0;

endmodule

`default_nettype wire

// File: rtl/result_dispatcher.sv
//------------------------------------------------------------------------------
// Module  : result_dispatcher
// Brief   : Drains the result FIFO to the master that issued the job.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module result_dispatcher
    import ip_pkg::*;
#(
    parameter int DW = c_DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] fifo_rd_data,
    input  logic          fifo_empty,
    output logic          fifo_rd_en,
    input  logic          data_source,
    input  logic          proc_cmplt,
    output logic [DW-1:0] mstr0_data,
    output logic          mstr0_data_valid,
    input  logic          mstr0_ready,
    output logic [DW-1:0] mstr1_data,
    output logic          mstr1_data_valid,
    input  logic          mstr1_ready,
    output logic          mstr0_cmplt,
    output logic          mstr1_cmplt,
    output logic          busy
);

    disp_state_t   r_state;
    disp_state_t   w_state_nxt;
    logic          r_dst;
    logic          r_inflight;
    logic [1:0]    w_occ;
    logic [DW-1:0] w_head;
    logic          w_sel_ready;
    logic          w_pop;
    logic [2:0]    w_level;
    logic          w_rd_en;
    logic          w_latch_dst;

    assign w_sel_ready = r_dst ? mstr1_ready : mstr0_ready;
    assign w_pop       = (w_occ != 2'd0) && w_sel_ready;
    // Slots that will still be claimed after this cycle's handshake.
    assign w_level     = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_rd_en     = ((r_state == ST_STREAM) || (r_state == ST_FLUSH))
                         && !fifo_empty && (w_level < 3'd2);
    assign w_latch_dst = (r_state == ST_IDLE) && (proc_cmplt || !fifo_empty);

    skid_buf2 #(
        .DW (DW)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .i_push      (r_inflight),
        .i_push_data (fifo_rd_data),
        .i_pop       (w_pop),
        .o_occ       (w_occ),
        .o_head      (w_head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_dst      <= 1'b0;
            r_inflight <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_rd_en;
            if (w_latch_dst) r_dst <= data_source;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (proc_cmplt)       w_state_nxt = ST_FLUSH;
                else if (!fifo_empty) w_state_nxt = ST_STREAM;
            end
            ST_STREAM: begin
                if (proc_cmplt) w_state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (fifo_empty && (w_occ == 2'd0) && !r_inflight) w_state_nxt = ST_CMPLT;
            end
            ST_CMPLT: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        fifo_rd_en       = w_rd_en;
        busy             = (r_state != ST_IDLE);
        mstr0_data_valid = (w_occ != 2'd0) && !r_dst;
        mstr1_data_valid = (w_occ != 2'd0) &&  r_dst;
        mstr0_data       = mstr0_data_valid ? w_head : '0;
        mstr1_data       = mstr1_data_valid ? w_head : '0;
        mstr0_cmplt      = (r_state == ST_CMPLT) && !r_dst;
        mstr1_cmplt      = (r_state == ST_CMPLT) &&  r_dst;
    end

endmodule

`default_nettype wire
